encoder_serial_rr: RTL and testbench

ENCODER_SERIAL_RR -- requirements
Module: encoder_serial_rr

---
 rtl/encoder_pkg.sv | 22 ++
 rtl/encoder_serial_rr_if.sv | 40 ++++
 rtl/encoder_pick.sv | 46 ++++
 rtl/encoder_serial_rr.sv | 123 ++++++++++++
 tb/tb_encoder_serial_rr.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_pkg
//  Description : Shared definitions for the serial round-robin encoder:
//                controller state encoding and the mode select values.
//  Contents    : state_t    - IDLE (accepting a vector) / EMIT (serving it)
//                MODE_FIXED - highest set index first
//                MODE_RR    - ascending from the persistent pointer, wrapping
//  Revision    : 1.0 - initial release
// ============================================================================
package encoder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage : encoder_pkg
`default_nettype wire

// File: rtl/encoder_serial_rr_if.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_serial_rr_if
//  Description : Request-vector input channel and encoded-index output
//                channel of the serial encoder, bundled as one interface.
//  Signals     : in/in_valid/in_ready/mode    - vector input handshake
//                out_idx/out_valid/out_ready  - index output handshake
//                out_last                     - index is the final one
//                zero_err                     - all-zero vector accepted
//  Modports    : slave  - the encoder side
//                master - the producer/consumer side
//  Revision    : 1.0 - initial release
// ============================================================================
interface encoder_serial_rr_if #(
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             zero_err;

    modport slave (
        input  in, in_valid, mode, out_ready,
        output in_ready, out_idx, out_valid, out_last, zero_err
    );

    modport master (
        output in, in_valid, mode, out_ready,
        input  in_ready, out_idx, out_valid, out_last, zero_err
    );

endinterface : encoder_serial_rr_if
`default_nettype wire

// File: rtl/encoder_pick.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_pick
//  Description : Combinational masked search with wrap. Scans the vector
//                starting at start_i, stepping up (dir_i=1) or down
//                (dir_i=0) modulo WIDTH, and reports the first set bit.
//  Ports       : vec_i   [WIDTH] - candidate bits
//                start_i [IDX_W] - first position examined (< WIDTH)
//                dir_i           - 1 ascending, 0 descending
//                idx_o   [IDX_W] - first set position found (0 if none)
//                found_o         - any bit set
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder_pick #(
    parameter int WIDTH = 8
) (
    input  wire logic [WIDTH-1:0]         vec_i,
    input  wire logic [$clog2(WIDTH)-1:0] start_i,
    input  wire logic                     dir_i,
    output logic      [$clog2(WIDTH)-1:0] idx_o,
    output logic                          found_o
);
    localparam int IDX_W = $clog2(WIDTH);

    int pos;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        pos     = 0;
        for (int k = 0; k < WIDTH; k++) begin
            // Adding WIDTH before the modulo keeps the descending walk positive.
            if (dir_i) begin
                pos = (int'(start_i) + k) % WIDTH;
            end else begin
                pos = (int'(start_i) - k + WIDTH) % WIDTH;
            end
            if (!found_o && vec_i[pos[IDX_W-1:0]]) begin
                found_o = 1'b1;
                idx_o   = pos[IDX_W-1:0];
            end
        end
    end

endmodule : encoder_pick
`default_nettype wire

// File: rtl/encoder_serial_rr.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_serial_rr
//  Description : Accepts a request vector and serially emits the index of
//                each set bit, one per output handshake. Fixed mode emits
//                highest index first; round-robin mode emits ascending from
//                a pointer that persists across vectors. An all-zero vector
//                produces a one-cycle zero_err pulse instead of output.
//  Ports       : clk    - rising-edge clock
//                rst_n  - synchronous active-low reset
//                enc_if - encoder_serial_rr_if.slave (vector in, index out)
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder_serial_rr
    import encoder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    encoder_serial_rr_if.slave  enc_if
);
    localparam int                 IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WIDTH - 1);

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("encoder_serial_rr: WIDTH must be at least 2");
        end
    endgenerate

    state_t           state_q;
    logic [WIDTH-1:0] held_q, held_d;
    logic             mode_q, mode_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] out_idx_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic             zero_err_q;

    logic             in_hs;
    logic             out_hs;
    logic [IDX_W-1:0] pick_start;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             last_d;

    // Everything below is computed on the vector the block will hold after
    // this edge, so the next index is registered straight away (no bubble)
    // and a stalled cycle simply recomputes the same answer.
    always_comb begin
        in_hs  = (state_q == IDLE) && enc_if.in_valid;
        out_hs = out_valid_q && enc_if.out_ready;
        held_d = held_q;
        mode_d = mode_q;
        ptr_d  = ptr_q;
        if (in_hs) begin
            held_d = enc_if.in;
            mode_d = enc_if.mode;
        end else if (out_hs) begin
            held_d = held_q & ~(WIDTH'(1) << out_idx_q);
            if (mode_q == MODE_RR) begin
                ptr_d = (out_idx_q == LAST_IDX) ? '0 : out_idx_q + 1'b1;
            end
        end
        pick_start = (mode_d == MODE_RR) ? ptr_d : LAST_IDX;
        last_d     = (held_d != '0) && ((held_d & (held_d - WIDTH'(1))) == '0);
    end

    encoder_pick #(
        .WIDTH   (WIDTH)
    ) u_pick (
        .vec_i   (held_d),
        .start_i (pick_start),
        .dir_i   (mode_d),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            held_q      <= '0;
            mode_q      <= MODE_FIXED;
            ptr_q       <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            zero_err_q  <= 1'b0;
        end else begin
            held_q     <= held_d;
            mode_q     <= mode_d;
            ptr_q      <= ptr_d;
            zero_err_q <= in_hs && (enc_if.in == '0);

            case (state_q)
                IDLE: if (in_hs && pick_found) state_q <= EMIT;
                EMIT: if (out_hs && !pick_found) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            // The held vector is empty whenever the next state is IDLE, so
            // pick_found alone decides whether an index is presented.
            if (pick_found) begin
                out_valid_q <= 1'b1;
                out_idx_q   <= pick_idx;
                out_last_q  <= last_d;
            end else begin
                out_valid_q <= 1'b0;
                out_idx_q   <= '0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign enc_if.in_ready  = (state_q == IDLE);
    assign enc_if.out_idx   = out_idx_q;
    assign enc_if.out_valid = out_valid_q;
    assign enc_if.out_last  = out_last_q;
    assign enc_if.zero_err  = zero_err_q;

endmodule : encoder_serial_rr
`default_nettype wire

// File: tb/tb_encoder_serial_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoder_serial_rr
//  Description : Self-checking bench for encoder_serial_rr (WIDTH=8 and a
//                WIDTH=4 instance). Expected index sequences come from a
//                list-based reference model of the emission order rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_serial_rr;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    encoder_serial_rr_if #(.WIDTH(8)) b8();
    encoder_serial_rr_if #(.WIDTH(4)) b4();

    encoder_serial_rr #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .enc_if(b8));
    encoder_serial_rr #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .enc_if(b4));

    int errors  = 0;
    int checks  = 0;
    int ref_ptr = 0;
    int exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Emission order for an 8-bit vector: fixed = set bits high to low,
    // round-robin = set bits visited upward from the pointer with wrap.
    task automatic model_build(input logic [7:0] v, input logic m);
        exp_q.delete();
        if (!m) begin
            for (int i = 7; i >= 0; i--) if (v[i]) exp_q.push_back(i);
        end else begin
            for (int k = 0; k < 8; k++) begin
                int p;
                p = (ref_ptr + k) % 8;
                if (v[p]) exp_q.push_back(p);
            end
        end
    endtask

    // Offer one vector, then serve it; stall<0 picks a random hold per index.
    // Inputs are scrambled during emission to show they are ignored.
    task automatic run_vec(input logic [7:0] v, input logic m, input int stall);
        int n;
        chk("in_ready_idle", 32'(b8.in_ready), 1);
        b8.in        = v;
        b8.in_valid  = 1'b1;
        b8.mode      = m;
        b8.out_ready = 1'b0;
        model_build(v, m);
        step();
        if (v == 8'h00) begin
            b8.in_valid = 1'b0;
            chk("zero_err_pulse", 32'(b8.zero_err), 1);
            chk("zero_no_valid", 32'(b8.out_valid), 0);
            chk("zero_in_ready", 32'(b8.in_ready), 1);
            step();
            chk("zero_err_clear", 32'(b8.zero_err), 0);
            chk("zero_no_valid2", 32'(b8.out_valid), 0);
            return;
        end
        for (int j = 0; j < exp_q.size(); j++) begin
            n = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            for (int s = 0; s <= n; s++) begin
                chk("out_valid", 32'(b8.out_valid), 1);
                chk("out_idx", 32'(b8.out_idx), 32'(exp_q[j]));
                chk("out_last", 32'(b8.out_last), 32'(j == exp_q.size() - 1));
                chk("in_ready_emit", 32'(b8.in_ready), 0);
                chk("zero_err_emit", 32'(b8.zero_err), 0);
                b8.in        = 8'($urandom);
                b8.in_valid  = 1'($urandom);
                b8.mode      = 1'($urandom);
                b8.out_ready = (s == n);
                step();
            end
            if (m) ref_ptr = (exp_q[j] + 1) % 8;
        end
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b0;
        chk("done_valid", 32'(b8.out_valid), 0);
        chk("done_idx", 32'(b8.out_idx), 0);
        chk("done_last", 32'(b8.out_last), 0);
        chk("done_in_ready", 32'(b8.in_ready), 1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        ref_ptr = 0;
    endtask

    initial begin
        logic [7:0] rv;
        b8.in = '0; b8.in_valid = 1'b0; b8.mode = 1'b0; b8.out_ready = 1'b0;
        b4.in = '0; b4.in_valid = 1'b0; b4.mode = 1'b0; b4.out_ready = 1'b0;

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(b8.out_valid), 0);
        chk("rst_idx", 32'(b8.out_idx), 0);
        chk("rst_last", 32'(b8.out_last), 0);
        chk("rst_zero_err", 32'(b8.zero_err), 0);
        chk("rst_in_ready", 32'(b8.in_ready), 1);
        chk("rst4_in_ready", 32'(b4.in_ready), 1);
        rst_n = 1'b1;

        // Fixed priority, full throughput
        run_vec(8'b1010_0100, 1'b0, 0);

        // Round-robin from a fresh pointer, then wrap
        pulse_reset();
        run_vec(8'b0000_0100, 1'b1, 0);
        run_vec(8'b0000_0101, 1'b1, 0);

        // Back-pressure
        run_vec(8'b1010_0100, 1'b0, 3);

        // All-zero vector
        run_vec(8'h00, 1'b0, 0);

        // Reset mid-emission: pointer at 5, first index of 8'hFF is 5
        run_vec(8'h10, 1'b1, 0);
        b8.in = 8'hFF; b8.in_valid = 1'b1; b8.mode = 1'b1; b8.out_ready = 1'b0;
        step();
        b8.in_valid = 1'b0;
        chk("ff_first_valid", 32'(b8.out_valid), 1);
        chk("ff_first_idx", 32'(b8.out_idx), 5);
        pulse_reset();
        b8.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_mid_valid", 32'(b8.out_valid), 0);
            chk("rst_mid_idx", 32'(b8.out_idx), 0);
            chk("rst_mid_last", 32'(b8.out_last), 0);
            chk("rst_mid_in_ready", 32'(b8.in_ready), 1);
            step();
        end
        b8.out_ready = 1'b0;
        run_vec(8'h81, 1'b1, 0);
        run_vec(8'h01, 1'b1, 0);

        // WIDTH=4 fixed priority
        b4.in = 4'b1111; b4.in_valid = 1'b1; b4.mode = 1'b0; b4.out_ready = 1'b1;
        step();
        b4.in_valid = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            chk("w4_valid", 32'(b4.out_valid), 1);
            chk("w4_idx", 32'(b4.out_idx), 32'(i));
            chk("w4_last", 32'(b4.out_last), 32'(i == 0));
            step();
        end
        chk("w4_done_valid", 32'(b4.out_valid), 0);
        chk("w4_done_in_ready", 32'(b4.in_ready), 1);

        // Randomized vectors, modes and stalls
        for (int t = 0; t < 40; t++) begin
            rv = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            run_vec(rv, 1'($urandom), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_encoder_serial_rr
`default_nettype wire
